// File: rtl/vga_if.sv
// vga_if -- pixel stream bundle between the VGA timing generator and the
// drawing chain.
//
// Signals:
//   hcount[10:0]  horizontal pixel position of the current pixel
//   vcount[10:0]  line number of the current pixel
//   hsync, vsync  active-high sync pulses (polarity fixed up at the top level)
//   hblnk, vblnk  blanking flags
//   rgb[11:0]     4:4:4 pixel colour
//
// Modports:
//   vga_out  stream source (timing generator / drawing stage output)
//   vga_in   stream sink   (next drawing stage input)
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// vga_timing -- VGA raster timing generator and head of the drawing chain.
//
// Produces the horizontal/vertical pixel counters, sync pulses and blanking
// flags for one display mode (default 1024x768 @ 1344x806 total). Every
// output is registered from the same next-position value, so on any cycle
// hcount, vcount, the flags, rgb and frame_start all describe one pixel.
//
// Ports:
//   clk          pixel clock, rising edge
//   rst          synchronous, active-high reset; all outputs forced to 0
//   vga_out      vga_if.vga_out stream source (counters, syncs, blanks, rgb)
//   frame_start  one-cycle strobe while the output position is (0,0)
//
// Build option:
//   VGA_TIMING_TEST_PATTERN_EN  when defined, rgb carries eight colour bars
//                               in the active area (selected by hcount[9:7]);
//                               when undefined rgb is constant 12'h000.
module vga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic   clk,
  input  logic   rst,
  vga_if.vga_out vga_out,
  output logic   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST        = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLANK_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END    = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [10:0] V_LAST        = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLANK_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [10:0] next_h;
  logic [10:0] next_v;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  // Next raster position. The >= compares (rather than ==) mean a corrupted
  // counter still wraps instead of running past the total.
  always_comb begin
    next_h = hcount + 11'd1;
    next_v = vcount;
    if (hcount >= H_LAST) begin
      next_h = 11'd0;
      next_v = (vcount >= V_LAST) ? 11'd0 : vcount + 11'd1;
    end
  end

  // Flags are decoded from the next position and registered alongside the
  // counters, so they line up with the pixel they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= next_h;
      vcount      <= next_v;
      hblnk       <= (next_h >= H_BLANK_START);
      hsync       <= (next_h >= H_SYNC_START) && (next_h < H_SYNC_END);
      vblnk       <= (next_v >= V_BLANK_START);
      vsync       <= (next_v >= V_SYNC_START) && (next_v < V_SYNC_END);
      frame_start <= (next_h == 11'd0) && (next_v == 11'd0);
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic        next_active;
  logic [11:0] bar_rgb;

  // Eight 128-pixel-wide colour bars across the visible line.
  always_comb begin
    next_active = (next_h < H_BLANK_START) && (next_v < V_BLANK_START);
    case (next_h[9:7])
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= 12'h000;
    end else begin
      rgb <= next_active ? bar_rgb : 12'h000;
    end
  end
`else
  assign rgb = 12'h000;
`endif

  assign vga_out.hcount = hcount;
  assign vga_out.vcount = vcount;
  assign vga_out.hsync  = hsync;
  assign vga_out.vsync  = vsync;
  assign vga_out.hblnk  = hblnk;
  assign vga_out.vblnk  = vblnk;
  assign vga_out.rgb    = rgb;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing -- self-checking bench for vga_timing.
//
// Two instances share clk/rst: dut_full uses the default 1024x768 mode for
// line-level boundaries, dut_small uses a tiny 25x16 raster so whole frames
// fit in a short run. A raster model derived from the elapsed cycle count
// since reset predicts every output of both instances on every cycle.
module tb_vga_timing;

  localparam int SH_ACTIVE = 16;
  localparam int SH_FP     = 2;
  localparam int SH_SYNC   = 4;
  localparam int SH_BP     = 3;
  localparam int SV_ACTIVE = 10;
  localparam int SV_FP     = 1;
  localparam int SV_SYNC   = 2;
  localparam int SV_BP     = 3;

  typedef struct {
    int h;
    int v;
    int hs;
    int vs;
    int hb;
    int vb;
    int fs;
    int rgb;
  } exp_t;

  typedef struct {
    int adv;
    int h;
    int v;
    int hs;
    int vs;
    int hb;
    int vb;
    int fs;
  } vec_t;

  logic clk;
  logic rst;
  logic fs_full;
  logic fs_small;

  int t;
  int n_checks;
  int n_pass;

  vga_if bus_full();
  vga_if bus_small();

  vga_timing dut_full (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (bus_full),
    .frame_start (fs_full)
  );

  vga_timing #(
    .H_ACTIVE (SH_ACTIVE), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
    .V_ACTIVE (SV_ACTIVE), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP)
  ) dut_small (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (bus_small),
    .frame_start (fs_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bar_colour(input int idx);
    case (idx)
      0:       return 'hFFF;
      1:       return 'hFF0;
      2:       return 'h0FF;
      3:       return 'h0F0;
      4:       return 'hF0F;
      5:       return 'hF00;
      6:       return 'h00F;
      default: return 'h000;
    endcase
  endfunction

  // Expected outputs after n non-reset edges (n = 0 is the reset state).
  function automatic exp_t model(input int n, input int ha, input int hf,
                                 input int hw, input int hbp, input int va,
                                 input int vf, input int vw, input int vbp);
    exp_t e;
    int   ht;
    int   vt;
    ht    = ha + hf + hw + hbp;
    vt    = va + vf + vw + vbp;
    e.h   = n % ht;
    e.v   = (n / ht) % vt;
    e.hb  = int'(e.h >= ha);
    e.hs  = int'(e.h >= ha + hf && e.h < ha + hf + hw);
    e.vb  = int'(e.v >= va);
    e.vs  = int'(e.v >= va + vf && e.v < va + vf + vw);
    e.fs  = int'(n != 0 && (n % (ht * vt)) == 0);
    e.rgb = 0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    if (e.hb == 0 && e.vb == 0) e.rgb = bar_colour((e.h / 128) % 8);
`endif
    return e;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0d)", name, actual, expected, t);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e, input int h, input int v,
                             input int hs, input int vs, input int hb, input int vb,
                             input int fs, input int rgb);
    check_output({tag, ".hcount"}, h, e.h);
    check_output({tag, ".vcount"}, v, e.v);
    check_output({tag, ".hsync"}, hs, e.hs);
    check_output({tag, ".vsync"}, vs, e.vs);
    check_output({tag, ".hblnk"}, hb, e.hb);
    check_output({tag, ".vblnk"}, vb, e.vb);
    check_output({tag, ".frame_start"}, fs, e.fs);
    check_output({tag, ".rgb"}, rgb, e.rgb);
  endtask

  // One clock: advance the cycle count per the rst seen at the edge, then
  // compare both instances against the model.
  task automatic clock_cycle();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) t = 0;
    else   t = t + 1;
    compare_all("full", model(t, 1024, 24, 136, 160, 768, 3, 6, 29),
                int'(bus_full.hcount), int'(bus_full.vcount), int'(bus_full.hsync),
                int'(bus_full.vsync), int'(bus_full.hblnk), int'(bus_full.vblnk),
                int'(fs_full), int'(bus_full.rgb));
    compare_all("small", model(t, SH_ACTIVE, SH_FP, SH_SYNC, SH_BP,
                               SV_ACTIVE, SV_FP, SV_SYNC, SV_BP),
                int'(bus_small.hcount), int'(bus_small.vcount), int'(bus_small.hsync),
                int'(bus_small.vsync), int'(bus_small.hblnk), int'(bus_small.vblnk),
                int'(fs_small), int'(bus_small.rgb));
  endtask

  task automatic apply_stimulus(input logic rst_val, input int cycles);
    rst = rst_val;
    for (int i = 0; i < cycles; i++) clock_cycle();
  endtask

  vec_t vecs[10];
  int   hs_cnt;
  int   vs_cnt;
  int   hb_cnt;
  int   strobe_t[$];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    t        = 0;
    rst      = 1'b1;

    // Line-level boundaries of the default mode; adv is cycles since the
    // previous entry, starting from the reset state.
    //           adv   h     v  hs vs hb vb fs
    vecs[0] = '{1,    1,    0, 0, 0, 0, 0, 0};
    vecs[1] = '{127,  128,  0, 0, 0, 0, 0, 0};
    vecs[2] = '{895,  1023, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{1,    1024, 0, 0, 0, 1, 0, 0};
    vecs[4] = '{23,   1047, 0, 0, 0, 1, 0, 0};
    vecs[5] = '{1,    1048, 0, 1, 0, 1, 0, 0};
    vecs[6] = '{135,  1183, 0, 1, 0, 1, 0, 0};
    vecs[7] = '{1,    1184, 0, 0, 0, 1, 0, 0};
    vecs[8] = '{159,  1343, 0, 0, 0, 1, 0, 0};
    vecs[9] = '{1,    0,    1, 0, 0, 0, 0, 0};

    // Reset held for 5 cycles: every output of the default instance is 0.
    apply_stimulus(1'b1, 5);
    check_output("rst.hcount", int'(bus_full.hcount), 0);
    check_output("rst.vcount", int'(bus_full.vcount), 0);
    check_output("rst.flags", int'({bus_full.hsync, bus_full.vsync,
                                    bus_full.hblnk, bus_full.vblnk, fs_full}), 0);
    check_output("rst.rgb", int'(bus_full.rgb), 0);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, vecs[i].adv);
      check_output($sformatf("vec%0d.hcount", i), int'(bus_full.hcount), vecs[i].h);
      check_output($sformatf("vec%0d.vcount", i), int'(bus_full.vcount), vecs[i].v);
      check_output($sformatf("vec%0d.hsync", i), int'(bus_full.hsync), vecs[i].hs);
      check_output($sformatf("vec%0d.vsync", i), int'(bus_full.vsync), vecs[i].vs);
      check_output($sformatf("vec%0d.hblnk", i), int'(bus_full.hblnk), vecs[i].hb);
      check_output($sformatf("vec%0d.vblnk", i), int'(bus_full.vblnk), vecs[i].vb);
      check_output($sformatf("vec%0d.frame_start", i), int'(fs_full), vecs[i].fs);
    end

    // One whole line of the default mode: 136 hsync cycles, 320 blank cycles.
    hs_cnt = 0;
    hb_cnt = 0;
    for (int i = 0; i < 1344; i++) begin
      apply_stimulus(1'b0, 1);
      hs_cnt += int'(bus_full.hsync);
      hb_cnt += int'(bus_full.hblnk);
    end
    check_output("line.hsync_cycles", hs_cnt, 136);
    check_output("line.hblnk_cycles", hb_cnt, 320);

    // Small raster: two frames from reset, counting sync cycles over the
    // first frame and recording every frame_start.
    apply_stimulus(1'b1, 1);
    hs_cnt = 0;
    vs_cnt = 0;
    for (int i = 0; i < 850; i++) begin
      apply_stimulus(1'b0, 1);
      if (t <= 400) begin
        hs_cnt += int'(bus_small.hsync);
        vs_cnt += int'(bus_small.vsync);
      end
      if (fs_small) strobe_t.push_back(t);
    end
    check_output("frame.hsync_cycles", hs_cnt, SH_SYNC * 16);
    check_output("frame.vsync_cycles", vs_cnt, SV_SYNC * 25);
    check_output("frame.strobe_count", strobe_t.size(), 2);
    check_output("frame.first_strobe", (strobe_t.size() > 0) ? strobe_t[0] : -1, 400);
    check_output("frame.strobe_gap",
                 (strobe_t.size() > 1) ? strobe_t[1] - strobe_t[0] : -1, 400);

    // Mid-frame reset at small position (10,5), then restart.
    apply_stimulus(1'b1, 1);
    apply_stimulus(1'b0, 135);
    check_output("mid.hcount_before", int'(bus_small.hcount), 10);
    check_output("mid.vcount_before", int'(bus_small.vcount), 5);
    apply_stimulus(1'b1, 1);
    check_output("mid.all_zero", int'({bus_small.hcount, bus_small.vcount, bus_small.hsync,
                                       bus_small.vsync, bus_small.hblnk, bus_small.vblnk,
                                       fs_small, bus_small.rgb}), 0);
    apply_stimulus(1'b0, 1);
    check_output("mid.hcount_after", int'(bus_small.hcount), 1);
    check_output("mid.vcount_after", int'(bus_small.vcount), 0);
    check_output("mid.frame_start_after", int'(fs_small), 0);

    // Random run with occasional resets, checked cycle by cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1);
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
